drp_rmw_seq: RTL
================

// Module: drp_rmw_seq
// PURPOSE
//  Command sequencer upstream of the DRP request/acknowledge controller. Accepts read, write,
//  read-modify-write (RMW) and RMW-with-verify commands, issues single cfg read/write requests,
//  merges masked fields and checks acks against a timeout. Gives MMCM/XADC reconfiguration logic
//  a one-command-per-field interface instead of raw DRP cycles.
// PARAMETERS
//  TMO_CNT   256   max cycles waiting for cfg_ack_i per access before timeout (1..65535)
// PORTS
//  cfg_clk_i    in   1   clock; all logic on rising edge
//  cfg_rstn_i   in   1   reset, asynchronous assert, active-low
//  cmd_valid_i  in   1   command valid
//  cmd_ready_o  out  1   command accept; transfer when cmd_valid_i && cmd_ready_o
//  cmd_op_i     in   2   0=read, 1=write, 2=RMW, 3=RMW+verify
//  cmd_adr_i    in   7   DRP address
//  cmd_msk_i    in   16  RMW: 1 = bit taken from cmd_dat_i (ignored for op 0/1)
//  cmd_dat_i    in   16  write data / RMW field data
//  rsp_valid_o  out  1   one-cycle response pulse
//  rsp_err_o    out  2   0=ok, 1=ack timeout, 2=verify mismatch
//  rsp_dat_o    out  16  read value (op0), written value (op1/2), readback (op3); held until next rsp
//  busy_o       out  1   high from accept until rsp_valid_o cycle inclusive
//  cfg_adr_o    out  7   to DRP controller: address
//  cfg_re_o     out  1   to DRP controller: one-cycle read request
//  cfg_we_o     out  1   to DRP controller: one-cycle write request
//  cfg_dat_o    out  16  to DRP controller: write data, valid with cfg_we_o
//  cfg_dat_i    in   16  from DRP controller: read data, valid with cfg_ack_i
//  cfg_ack_i    in   1   from DRP controller: one-cycle access complete
//  cfg_bsy_i    in   1   from DRP controller: access in progress
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready_o=1; rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, busy_o=0;
//    cfg_re_o=cfg_we_o=0, cfg_adr_o=0, cfg_dat_o=0; timeout counter=0. Reset mid-command aborts
//    it silently; no response is produced.
//  - FSM: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, VF_REQ, VF_WAIT, RESP.
//    IDLE: cmd_ready_o=1 only here; on accept latch op/adr/msk/dat; op0,2,3->RD_REQ, op1->WR_REQ.
//    *_REQ: wait for cfg_bsy_i==0, then pulse cfg_re_o (RD/VF) or cfg_we_o (WR) for exactly
//      one cycle with cfg_adr_o/cfg_dat_o and go to matching *_WAIT. No request while cfg_bsy_i=1.
//    RD_WAIT on ack: capture cfg_dat_i; op0 -> RESP; op2/3: wdat=(rd & ~msk)|(dat & msk) -> WR_REQ.
//    WR_WAIT on ack: op3 -> VF_REQ, else RESP with rsp_dat_o=written value.
//    VF_WAIT on ack: rsp_dat_o=cfg_dat_i; err=2 if cfg_dat_i != written value -> RESP.
//    RESP: rsp_valid_o=1 one cycle -> IDLE. Next accept earliest next cycle.
//  - Registered outputs; cfg_re_o/cfg_we_o never high together; cfg_adr_o/cfg_dat_o return to 0
//    when no request is pulsed.
//  - Timeout: counter clears on entry to each *_WAIT and counts each cycle without cfg_ack_i;
//    on reaching TMO_CNT -> RESP with err=1, rsp_dat_o=0, remaining accesses skipped.
//    An ack in the same cycle as the counter reaching TMO_CNT counts as success.
//  - Late ack (arrives in IDLE/REQ after a timeout) is ignored; since the next request waits on
//    cfg_bsy_i, a stuck controller stalls in *_REQ (no timeout applies there).
//  - Ack outside a *_WAIT state is ignored; cfg_dat_i is sampled only with cfg_ack_i.
//  - cmd_msk_i=0x0000 on RMW writes back the unchanged read value; 0xFFFF writes cmd_dat_i.
// TESTING
//  - op0 adr=0x28, model returns 0x1234 after 5 cycles -> 1 cfg_re_o pulse, rsp_dat_o=0x1234, err=0
//  - op2 adr=0x08, read 0xA5A5, msk=0x00FF dat=0x0012 -> cfg_we_o with cfg_dat_o=0xA512, rsp=0xA512
//  - op3, model corrupts readback to 0xA513 -> read, write, read pulses; err=2, rsp_dat_o=0xA513
//  - TMO_CNT=16, model never acks read -> rsp_valid_o exactly 16 cycles after entering RD_WAIT, err=1
//  - cfg_bsy_i held high 10 cycles at accept -> no cfg_re_o until bsy low; back-to-back commands,
//    cmd_valid_i held high -> second accepted only after first rsp_valid_o
//  - cfg_rstn_i asserted during WR_WAIT -> all outputs to reset values immediately, no rsp_valid_o

Source files
------------

// File: rtl/drp_rmw_seq_if.sv
// Command/response and DRP-controller signals of the read-modify-write sequencer.
// The slave modport is the sequencer's view; master is the view of whoever drives it.
interface drp_rmw_seq_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [6:0]  cmd_adr_i;
    logic [15:0] cmd_msk_i;
    logic [15:0] cmd_dat_i;
    logic        rsp_valid_o;
    logic [1:0]  rsp_err_o;
    logic [15:0] rsp_dat_o;
    logic        busy_o;
    logic [6:0]  cfg_adr_o;
    logic        cfg_re_o;
    logic        cfg_we_o;
    logic [15:0] cfg_dat_o;
    logic [15:0] cfg_dat_i;
    logic        cfg_ack_i;
    logic        cfg_bsy_i;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_msk_i, cmd_dat_i,
        input  cfg_dat_i, cfg_ack_i, cfg_bsy_i,
        output cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_dat_o, busy_o,
        output cfg_adr_o, cfg_re_o, cfg_we_o, cfg_dat_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_msk_i, cmd_dat_i,
        output cfg_dat_i, cfg_ack_i, cfg_bsy_i,
        input  cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_dat_o, busy_o,
        input  cfg_adr_o, cfg_re_o, cfg_we_o, cfg_dat_o
    );
endinterface

// File: rtl/drp_rmw_seq.sv
// Sequencer turning read / write / RMW / RMW+verify commands into single DRP accesses,
// with masked field merge, readback verify and a per-access ack timeout.
module drp_rmw_seq #(
    parameter int unsigned TMO_CNT = 256
) (
    input  logic             cfg_clk_i,
    input  logic             cfg_rstn_i,
    drp_rmw_seq_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, VF_REQ, VF_WAIT, RESP
    } state_e;

    localparam logic [1:0]  OP_RD     = 2'd0;
    localparam logic [1:0]  OP_WR     = 2'd1;
    localparam logic [1:0]  OP_RMW_VF = 2'd3;
    localparam logic [1:0]  ERR_OK    = 2'd0;
    localparam logic [1:0]  ERR_TMO   = 2'd1;
    localparam logic [1:0]  ERR_VF    = 2'd2;
    localparam logic [15:0] TMO_LAST  = 16'(TMO_CNT - 1);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [6:0]  adr_q, adr_d;
    logic [15:0] msk_q, msk_d;
    logic [15:0] dat_q, dat_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] tmo_q, tmo_d;

    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic [15:0] rsp_dat_q, rsp_dat_d;
    logic [6:0]  cfg_adr_q, cfg_adr_d;
    logic        cfg_re_q, cfg_re_d;
    logic        cfg_we_q, cfg_we_d;
    logic [15:0] cfg_dat_q, cfg_dat_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cfg_clk_i or negedge cfg_rstn_i) begin
        if (!cfg_rstn_i) begin
            state_q     <= IDLE;
            op_q        <= '0;
            adr_q       <= '0;
            msk_q       <= '0;
            dat_q       <= '0;
            wdat_q      <= '0;
            tmo_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_OK;
            rsp_dat_q   <= '0;
            cfg_adr_q   <= '0;
            cfg_re_q    <= 1'b0;
            cfg_we_q    <= 1'b0;
            cfg_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            adr_q       <= adr_d;
            msk_q       <= msk_d;
            dat_q       <= dat_d;
            wdat_q      <= wdat_d;
            tmo_q       <= tmo_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            cfg_adr_q   <= cfg_adr_d;
            cfg_re_q    <= cfg_re_d;
            cfg_we_q    <= cfg_we_d;
            cfg_dat_q   <= cfg_dat_d;
        end
    end

    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        adr_d     = adr_q;
        msk_d     = msk_q;
        dat_d     = dat_q;
        wdat_d    = wdat_q;
        tmo_d     = tmo_q;
        rsp_err_d = rsp_err_q;
        rsp_dat_d = rsp_dat_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    op_d    = bus.cmd_op_i;
                    adr_d   = bus.cmd_adr_i;
                    msk_d   = bus.cmd_msk_i;
                    dat_d   = bus.cmd_dat_i;
                    wdat_d  = bus.cmd_dat_i;
                    state_d = (bus.cmd_op_i == OP_WR) ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ, WR_REQ, VF_REQ: begin
                if (!bus.cfg_bsy_i) begin
                    tmo_d   = '0;
                    state_d = (state_q == RD_REQ) ? RD_WAIT :
                              (state_q == WR_REQ) ? WR_WAIT : VF_WAIT;
                end
            end
            RD_WAIT, WR_WAIT, VF_WAIT: begin
                if (bus.cfg_ack_i) begin
                    state_d = RESP;
                    if (state_q == RD_WAIT) begin
                        if (op_q == OP_RD) begin
                            rsp_dat_d = bus.cfg_dat_i;
                            rsp_err_d = ERR_OK;
                        end else begin
                            wdat_d  = (bus.cfg_dat_i & ~msk_q) | (dat_q & msk_q);
                            state_d = WR_REQ;
                        end
                    end else if (state_q == WR_WAIT) begin
                        if (op_q == OP_RMW_VF) begin
                            state_d = VF_REQ;
                        end else begin
                            rsp_dat_d = wdat_q;
                            rsp_err_d = ERR_OK;
                        end
                    end else begin
                        rsp_dat_d = bus.cfg_dat_i;
                        rsp_err_d = (bus.cfg_dat_i != wdat_q) ? ERR_VF : ERR_OK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Timeout abandons any accesses the command still had to do.
                    state_d   = RESP;
                    rsp_err_d = ERR_TMO;
                    rsp_dat_d = '0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered: next-cycle values derive from the current request and next state.
    always_comb begin
        cfg_re_d    = !bus.cfg_bsy_i && (state_q == RD_REQ || state_q == VF_REQ);
        cfg_we_d    = !bus.cfg_bsy_i && (state_q == WR_REQ);
        cfg_adr_d   = (cfg_re_d || cfg_we_d) ? adr_q : '0;
        cfg_dat_d   = cfg_we_d ? wdat_q : '0;
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    assign bus.cmd_ready_o = ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.cfg_adr_o   = cfg_adr_q;
    assign bus.cfg_re_o    = cfg_re_q;
    assign bus.cfg_we_o    = cfg_we_q;
    assign bus.cfg_dat_o   = cfg_dat_q;

endmodule
